// File: rtl/pump_channel_array.sv
// pump_channel_array: multi-channel pump driver fed by the Pico 4-bit REQ/ACK link.
// Three-nibble frames set a per-channel target duty. Each channel's live duty
// ramps toward its effective target, and a debounced dry sensor cuts the channel.
// Optional feature macro: PUMP_ARRAY_WATCHDOG_EN. When it is defined, a link
// watchdog ramps every channel down if no valid frame arrives within WDT_CYC clocks.
module pump_channel_array #(
  parameter int NUM_CH       = 2,
  parameter int DUTY_W       = 8,
  parameter int RAMP_DIV     = 50_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int WDT_CYC      = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        data,
  input  logic              req,
  output logic              ack,
  input  logic [NUM_CH-1:0] sensor_dry,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] ch_running,
  output logic [NUM_CH-1:0] interlock,
  output logic              frame_err,
  output logic              wdt_trip
);

  localparam int PRE_W = $clog2(RAMP_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);

  // Reject parameter sets the channel index and prescaler cannot represent.
  if (NUM_CH < 1 || NUM_CH > 8 || RAMP_DIV < 2 || DEBOUNCE_CYC < 1 || WDT_CYC < 1) begin : g_param_check
    $error("pump_channel_array: parameter out of range");
  end

  typedef enum logic {IDLE, ACK_HI} hs_state_t;
  typedef enum logic [1:0] {F_IDLE, F_HI, F_LO} f_state_t;

  logic              req_meta, req_sync;
  logic [NUM_CH-1:0] sens_meta, sens_sync;

  hs_state_t  hs_state, hs_next;
  logic       ack_next, nib_capture, nib_valid;
  logic [3:0] nib;

  f_state_t          f_state, f_next;
  logic [2:0]        ch_reg, ch_next;
  logic [3:0]        hi_reg, hi_next;
  logic              err_next, tgt_we;
  logic [DUTY_W-1:0] tgt_val;

  logic [DUTY_W-1:0] target  [NUM_CH];
  logic [DUTY_W-1:0] duty    [NUM_CH];
  logic [DUTY_W-1:0] eff_tgt [NUM_CH];
  logic [DEB_W-1:0]  deb_cnt [NUM_CH];
  logic [PRE_W-1:0]  pre_cnt;
  logic              tick;
  logic [DUTY_W-1:0] pwm_cnt;

  // Two-flop synchronisers for the asynchronous link request and the level sensors.
  // Sensors come out of reset reading dry, so a wet tank is accepted one full
  // debounce window after reset, the same as any other sensor change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_meta  <= 1'b0;
      req_sync  <= 1'b0;
      sens_meta <= '1;
      sens_sync <= '1;
    end else begin
      // NOTE: registers use <= so every flop samples pre-edge values; = here would chain the two sync stages into one.
      req_meta  <= req;
      req_sync  <= req_meta;
      sens_meta <= sensor_dry;
      sens_sync <= sens_meta;
    end
  end

  // Handshake next state: take one nibble per req pulse and hold ack until req drops.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves a value unassigned and no latch is inferred.
    hs_next     = hs_state;
    ack_next    = ack;
    nib_capture = 1'b0;
    case (hs_state)
      IDLE: begin
        if (req_sync) begin
          hs_next     = ACK_HI;
          ack_next    = 1'b1;
          nib_capture = 1'b1;
        end
      end
      ACK_HI: begin
        if (!req_sync) begin
          hs_next  = IDLE;
          ack_next = 1'b0;
        end
      end
      default: hs_next = IDLE;
    endcase
  end

  // Handshake state register, registered ack and the captured nibble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_state  <= IDLE;
      ack       <= 1'b0;
      nib_valid <= 1'b0;
      nib       <= '0;
    end else begin
      hs_state  <= hs_next;
      ack       <= ack_next;
      nib_valid <= nib_capture;
      if (nib_capture) nib <= data;
    end
  end

  // Frame parser: a header nibble (bit3 set) always starts a new frame; data nibbles fill hi then lo.
  always_comb begin
    f_next   = f_state;
    ch_next  = ch_reg;
    hi_next  = hi_reg;
    err_next = 1'b0;
    tgt_we   = 1'b0;
    tgt_val  = DUTY_W'({hi_reg, nib});
    if (nib_valid) begin
      if (nib[3]) begin
        f_next  = F_HI;
        ch_next = nib[2:0];
      end else begin
        case (f_state)
          F_IDLE: err_next = 1'b1;
          F_HI: begin
            hi_next = nib;
            f_next  = F_LO;
          end
          F_LO: begin
            f_next = F_IDLE;
            if ({1'b0, ch_reg} < NUM_CH_L) tgt_we   = 1'b1;
            else                           err_next = 1'b1;
          end
          default: f_next = F_IDLE;
        endcase
      end
    end
  end

  // Frame state register, error pulse and per-channel target store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_state   <= F_IDLE;
      ch_reg    <= '0;
      hi_reg    <= '0;
      frame_err <= 1'b0;
      // NOTE: the target array is a handful of flops, so it is reset; a real RAM would not be.
      for (int i = 0; i < NUM_CH; i++) target[i] <= '0;
    end else begin
      f_state   <= f_next;
      ch_reg    <= ch_next;
      hi_reg    <= hi_next;
      frame_err <= err_next;
      for (int i = 0; i < NUM_CH; i++) begin
        if (tgt_we && ch_reg == 3'(i)) target[i] <= tgt_val;
      end
    end
  end

`ifdef PUMP_ARRAY_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYC + 1);
  logic [WDT_W-1:0] wdt_cnt;

  // Link watchdog: restarts on every valid frame; latches the trip once the timeout is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_cnt  <= '0;
      wdt_trip <= 1'b0;
    end else if (tgt_we) begin
      wdt_cnt  <= '0;
      wdt_trip <= 1'b0;
    end else if (wdt_cnt == WDT_W'(WDT_CYC)) begin
      wdt_trip <= 1'b1;
    end else begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end
`else
  assign wdt_trip = 1'b0;
`endif

  // Effective target: a dry channel or a tripped watchdog steers the ramp to zero.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      eff_tgt[i] = (interlock[i] || wdt_trip) ? '0 : target[i];
    end
  end

  // Shared ramp prescaler; tick marks the terminal count.
  assign tick = (pre_cnt == PRE_W'(RAMP_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Live duty: an interlocked channel is cut at once; otherwise step one count per tick toward the target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) duty[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (interlock[i])                 duty[i] <= '0;
        else if (tick && duty[i] < eff_tgt[i]) duty[i] <= duty[i] + 1'b1;
        else if (tick && duty[i] > eff_tgt[i]) duty[i] <= duty[i] - 1'b1;
      end
    end
  end

  // Sensor debounce: flip interlock only after the synced input has disagreed for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interlock <= '1;
      for (int i = 0; i < NUM_CH; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sens_sync[i] == interlock[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEBOUNCE_CYC)) begin
          interlock[i] <= ~interlock[i];
          deb_cnt[i]   <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Free-running PWM counter and registered comparators.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      pwm_out <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      for (int i = 0; i < NUM_CH; i++) pwm_out[i] <= (pwm_cnt < duty[i]);
    end
  end

  // Running flag per channel mirrors a non-zero live duty.
  always_comb begin
    ch_running = '0;
    for (int i = 0; i < NUM_CH; i++) ch_running[i] = (duty[i] != '0);
  end

endmodule

// File: tb/tb_pump_channel_array.sv
// tb_pump_channel_array: directed bench for pump_channel_array with small
// parameters. Expected frame_err per nibble is queued as each nibble is driven
// and popped when the DUT answers. Watchdog steps exist only when
// PUMP_ARRAY_WATCHDOG_EN is defined.
module tb_pump_channel_array;

  localparam int NUM_CH = 2;
  localparam int DUTY_W = 8;
  localparam int RDIV   = 4;
  localparam int DEB    = 8;
  localparam int WDT    = 400;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        data;
  logic              req;
  logic              ack;
  logic [NUM_CH-1:0] sensor_dry;
  logic [NUM_CH-1:0] pwm_out;
  logic [NUM_CH-1:0] ch_running;
  logic [NUM_CH-1:0] interlock;
  logic              frame_err;
  logic              wdt_trip;

  int tests = 0;
  int fails = 0;
  bit err_q[$];

  always #5 clk = ~clk;

  pump_channel_array #(
    .NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .RAMP_DIV(RDIV),
    .DEBOUNCE_CYC(DEB), .WDT_CYC(WDT)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .req(req), .ack(ack),
    .sensor_dry(sensor_dry), .pwm_out(pwm_out), .ch_running(ch_running),
    .interlock(interlock), .frame_err(frame_err), .wdt_trip(wdt_trip)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One REQ/ACK transfer; called and returning on a falling clock edge.
  task automatic send_nibble(input logic [3:0] n, input bit exp_err);
    int k;
    bit e;
    err_q.push_back(exp_err);
    data = n;
    req  = 1'b1;
    k = 0;
    while (ack !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    check("ack_rise_latency", k, 3);
    @(negedge clk);
    e = err_q.pop_front();
    check("frame_err", {31'b0, frame_err}, {31'b0, e});
    req = 1'b0;
    k = 0;
    while (ack !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    check("ack_fall_latency", k, 3);
  endtask

  task automatic wait_duty0(input logic [7:0] val, input int limit, output int k);
    k = 0;
    while (dut.duty[0] !== val && k < limit) begin @(negedge clk); k++; end
  endtask

  task automatic wait_il0(input logic val, input int limit, output int k);
    k = 0;
    while (interlock[0] !== val && k < limit) begin @(negedge clk); k++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int hi_cnt;
    reset = 1'b1; req = 1'b0; data = 4'h0; sensor_dry = '0;

    // Reset state.
    cycles(2);
    check("rst_ack", {31'b0, ack}, 0);
    check("rst_pwm", {30'b0, pwm_out}, 0);
    check("rst_running", {30'b0, ch_running}, 0);
    check("rst_frame_err", {31'b0, frame_err}, 0);
    check("rst_wdt", {31'b0, wdt_trip}, 0);
    check("rst_interlock", {30'b0, interlock}, 32'h3);
    reset = 1'b0;
    cycles(DEB + 2);
    check("il_before_debounce", {30'b0, interlock}, 32'h3);
    cycles(1);
    check("il_after_debounce", {30'b0, interlock}, 32'h0);

    // Frame ch0 duty 16 and ramp.
    send_nibble(4'h8, 1'b0);
    send_nibble(4'h1, 1'b0);
    send_nibble(4'h0, 1'b0);
    check("target0_set", dut.target[0], 16);
    check("target1_idle", dut.target[1], 0);
    wait_duty0(8'd2, 20, k);
    check("duty0_step2", dut.duty[0], 2);
    wait_duty0(8'd16, 200, k);
    check("ramp_2_to_16_cycles", k, 14 * RDIV);
    check("running_ch0", {30'b0, ch_running}, 32'h1);
    cycles(8);
    check("duty0_no_overshoot", dut.duty[0], 16);

    // Framing errors.
    send_nibble(4'h3, 1'b1);
    check("err_idle_t0", dut.target[0], 16);
    check("err_idle_t1", dut.target[1], 0);
    send_nibble(4'hA, 1'b0);
    send_nibble(4'h1, 1'b0);
    send_nibble(4'h0, 1'b1);
    check("bad_ch_t0", dut.target[0], 16);
    check("bad_ch_t1", dut.target[1], 0);
    send_nibble(4'h8, 1'b0);
    send_nibble(4'h2, 1'b0);
    send_nibble(4'h9, 1'b0);
    send_nibble(4'h1, 1'b0);
    send_nibble(4'h0, 1'b0);
    check("restart_t1", dut.target[1], 16);
    check("restart_t0", dut.target[0], 16);

    // PWM high time over one full period at duty 16.
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm_out[0] === 1'b1) hi_cnt++;
    end
    check("pwm0_high_count", hi_cnt, 16);

    // Refresh ch0 so the link stays alive through the interlock steps.
    send_nibble(4'h8, 1'b0);
    send_nibble(4'h1, 1'b0);
    send_nibble(4'h0, 1'b0);

    // Interlock: short glitch ignored, long dry cuts, release ramps back.
    sensor_dry = 2'b01;
    cycles(5);
    sensor_dry = 2'b00;
    cycles(15);
    check("glitch_interlock", {30'b0, interlock}, 0);
    check("glitch_duty0", dut.duty[0], 16);
    sensor_dry = 2'b01;
    wait_il0(1'b1, 30, k);
    check("il_rise_latency", k, DEB + 3);
    @(negedge clk);
    check("cut_duty0", dut.duty[0], 0);
    check("cut_running0", {31'b0, ch_running[0]}, 0);
    @(negedge clk);
    check("cut_pwm0", {31'b0, pwm_out[0]}, 0);
    check("cut_target0_kept", dut.target[0], 16);
    sensor_dry = 2'b00;
    wait_il0(1'b0, 30, k);
    check("il_fall_latency", k, DEB + 3);
    wait_duty0(8'd16, 120, k);
    check("reramp_duty0", dut.duty[0], 16);

    // Reset in the middle of a frame.
    send_nibble(4'h8, 1'b0);
    send_nibble(4'h1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ack", {31'b0, ack}, 0);
    check("midrst_t0", dut.target[0], 0);
    check("midrst_t1", dut.target[1], 0);
    check("midrst_il", {30'b0, interlock}, 32'h3);
    cycles(1);
    reset = 1'b0;
    cycles(DEB + 4);
    check("midrst_il_clear", {30'b0, interlock}, 0);
    send_nibble(4'h5, 1'b1);
    check("midrst_t0_after", dut.target[0], 0);

`ifdef PUMP_ARRAY_WATCHDOG_EN
    // Watchdog: silence trips a ramp-down; a valid frame clears it.
    send_nibble(4'h8, 1'b0);
    send_nibble(4'h1, 1'b0);
    send_nibble(4'h0, 1'b0);
    wait_duty0(8'd16, 100, k);
    check("wdt_ramp_up", dut.duty[0], 16);
    check("wdt_not_yet", {31'b0, wdt_trip}, 0);
    hi_cnt = k;
    k = 0;
    while (wdt_trip !== 1'b1 && k < 500) begin @(negedge clk); k++; end
    check("wdt_tripped", {31'b0, wdt_trip}, 1);
    check("wdt_trip_window", {31'b0, (k + hi_cnt >= 390) && (k + hi_cnt <= 402)}, 1);
    cycles(2);
    check("wdt_ramped_not_cut", {31'b0, dut.duty[0] >= 8'd15}, 1);
    wait_duty0(8'd0, 120, k);
    check("wdt_duty0_zero", dut.duty[0], 0);
    send_nibble(4'h8, 1'b0);
    send_nibble(4'h1, 1'b0);
    send_nibble(4'h0, 1'b0);
    check("wdt_cleared", {31'b0, wdt_trip}, 0);
`else
    check("wdt_tied_low", {31'b0, wdt_trip}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pump_channel_array.md
# pump_channel_array

Parametrised multi-channel pump driver that replaces the fixed two-pump handshake, level-sensor and PWM path in the filter core. It receives three-nibble command frames from the Pico over the 4-bit REQ/ACK link, holds a target duty per channel, slews each channel's live duty toward its target, and cuts any channel whose debounced dry-sensor reports no water. It sits between the Pico link pins and the pump output pins.

## Interface
- NUM_CH, 2, number of pump channels (1..8)
- DUTY_W, 8, duty and PWM counter width
- RAMP_DIV, 50_000, clocks per ramp step (≥2)
- DEBOUNCE_CYC, 1_000_000, stable cycles before a sensor change is accepted (20 ms at 50 MHz)
- WDT_CYC, 50_000_000, watchdog timeout in clocks (used only with the watchdog macro)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- data  in  4  command nibble, stable while req is high
- req  in  1  Pico request, asynchronous
- ack  out  1  acknowledge
- sensor_dry  in  NUM_CH  per-channel level sensor, asynchronous; '1' = dry, stop pump
- pwm_out  out  NUM_CH  pump PWM
- ch_running  out  NUM_CH  live duty ≠ 0
- interlock  out  NUM_CH  debounced dry state
- frame_err  out  1  one-cycle pulse on a rejected frame
- wdt_trip  out  1  watchdog tripped

## Operation
- **Reset values:**
  - ack=0, pwm_out=0, ch_running=0, frame_err=0, wdt_trip=0.
  - interlock=all 1: the safe state.
  - All targets, live duties, counters and frame state are 0.
- **Handshake:** req and each sensor_dry bit pass through a 2-flop synchroniser. Handshake states are IDLE → ACK_HI → IDLE.
  - In IDLE, when synced req is 1: capture data, set ack=1 and go to ACK_HI.
  - In ACK_HI, when synced req is 0: set ack=0 and go to IDLE.
  - Exactly one nibble is accepted per req pulse.
- **Frame format:**
  - N0 = {1, ch[2:0]}, then N1 = duty[7:4], then N2 = duty[3:0]. For DUTY_W≠8, the duty is the low DUTY_W bits of {N1,N2}.
  - Frame states are F_IDLE, F_HI, F_LO.
  - A nibble with bit3=0 while in F_IDLE is discarded and pulses frame_err.
  - A nibble with bit3=1 in F_HI or F_LO restarts the frame as a new N0. No error is flagged.
  - On N2, if ch < NUM_CH, target[ch] is written on the next edge. If ch ≥ NUM_CH, the frame is dropped and frame_err pulses.
- **Ramp:**
  - A shared prescaler counts 0..RAMP_DIV-1 and ticks at the terminal count.
  - On each tick, every channel's live duty moves by ±1 toward its effective target. It never overshoots.
  - The effective target is 0 when interlock[i]=1, otherwise target[i].
- **Interlock cut:**
  - When interlock[i] rises, live duty[i] is forced to 0 on the next edge, without ramping.
  - target[i] is retained. When interlock clears, the channel ramps up from 0.
- **Debounce:**
  - There is one counter per channel. It resets whenever the synced input equals interlock[i].
  - interlock[i] flips when the input has differed for DEBOUNCE_CYC consecutive cycles.
- **PWM:**
  - A shared free-running DUTY_W-bit counter wraps from 2^DUTY_W-1 to 0.
  - pwm_out[i] = (cnt < duty[i]), registered.
  - Duty 0 gives constant low. Full scale gives a period with one low cycle.
- **Simultaneous events:**
  - Interlock cut takes priority over a ramp tick.
  - A target write and a ramp tick in the same cycle: the tick uses the old target.
- **Reset mid-frame or mid-handshake:** everything returns to reset values immediately. A partial frame is lost.

## Timing
- req rising at a pin → ack=1 after 3 clk edges: 2 sync + 1 registered.
- req falling → ack=0 after 3 clk edges.
- N2 accepted → target updated 1 cycle after ack rises.
- Live duty reaches a target T from 0 in T×RAMP_DIV cycles (±RAMP_DIV for tick phase).
- sensor_dry change at a pin → interlock change after DEBOUNCE_CYC+3 cycles. The live-duty cut follows 1 cycle later, and the pwm_out low 1 cycle after that.
- frame_err pulses 1 cycle after the offending nibble's ack rise.

## Configuration
- **`PUMP_ARRAY_WATCHDOG_EN` defined:**
  - A counter resets on every accepted valid frame.
  - When the counter reaches WDT_CYC, wdt_trip=1 and all effective targets are forced to 0 (ramped down, not cut).
  - wdt_trip clears on the next valid frame.
- **Undefined:** no watchdog logic; wdt_trip is tied to 0.

## Test plan
Bench parameters: NUM_CH=2, RAMP_DIV=4, DEBOUNCE_CYC=8, WDT_CYC=400.
- **Reset:** hold reset for 2 cycles with sensor_dry=0 → all outputs 0 and interlock=2'b11. After 11 cycles, interlock=2'b00.
- **Frame and ramp:** send 0x8, 0x1, 0x0 (ch0, duty 16) → ack pulses 3 times and target0=16. Duty0 steps 0→16 over 64±4 cycles. pwm_out[0] is high 16 of every 256 cycles.
- **Framing errors:** send 0x3 in F_IDLE → frame_err pulse, nothing written. Send 0xA,0x1,0x0 (ch2) → frame_err pulse, targets unchanged. Send 0x8,0x2,0x9,0x1,0x0 → frame restarts, ch1 target=16, no error.
- **Interlock:** run ch0 at 16, then set sensor_dry[0]=1 for 5 cycles → no effect. Hold it for 12 cycles → interlock[0]=1 and duty0=0 within 12 cycles. Release the sensor → duty0 ramps back to 16.
- **Reset mid-frame:** after 0x8,0x1, assert reset → ack=0 and frame state is F_IDLE. A following 0x5 nibble pulses frame_err.
- **Watchdog (`PUMP_ARRAY_WATCHDOG_EN`):** with ch0=16 and no frames for 400 cycles → wdt_trip=1 and duty0 ramps to 0. A valid frame clears wdt_trip.
